// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//
// Issues one RV32I ALU-class instruction at a time to an external ALU and
// writes the ALU result back into a local 32x32 register file.
// Each instruction takes three cycles: IDLE (accept) -> ISSUE -> WB -> IDLE.
//
// Ports
//   clk, rst      : clock and synchronous active-high reset
//   in_instr/pc   : instruction word and its address offered for issue
//   in_valid      : offer strobe
//   in_ready      : high only in IDLE; transfer on in_valid & in_ready
//   alu_instr     : latched instruction presented to the ALU
//   alu_op1/op2   : decoded operands
//   alu_pc        : latched instruction address
//   alu_enable    : one-cycle issue strobe (ISSUE cycle, legal only)
//   alu_result    : registered ALU result, valid in the WB cycle
//   retire        : one-cycle completion pulse (WB cycle)
//   illegal       : one-cycle pulse alongside retire for non-ALU encodings
//   dbg_raddr/... : combinational register-file read port
//
// Configuration macro
//   ALU_SEQUENCER_ILLEGAL_HALT_EN : when defined, an illegal instruction
//   parks the sequencer in HALT (in_ready low) until rst. When undefined an
//   illegal instruction retires as a NOP and the HALT state does not exist.
// -----------------------------------------------------------------------------
module alu_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] alu_instr,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    output logic [31:0] alu_pc,
    output logic        alu_enable,
    input  logic [31:0] alu_result,
    output logic        retire,
    output logic        illegal,
    input  logic [4:0]  dbg_raddr,
    output logic [31:0] dbg_rdata
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WB    = 2'd2;
`ifdef ALU_SEQUENCER_ILLEGAL_HALT_EN
    localparam logic [1:0] ST_HALT  = 2'd3;
`endif

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    // Legality check of an instruction word for the ALU classes handled here.
    function automatic logic is_legal(input logic [31:0] ins);
        logic [6:0] f7;
        logic [2:0] f3;
        logic       ok;
        f7 = ins[31:25];
        f3 = ins[14:12];
        case (ins[6:0])
            OPC_OP: begin
                ok = (f7 == 7'h00) ||
                     ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)));
            end
            OPC_OPIMM: begin
                if (f3 == 3'b001) begin
                    ok = (f7 == 7'h00);
                end else if (f3 == 3'b101) begin
                    ok = (f7 == 7'h00) || (f7 == 7'h20);
                end else begin
                    ok = 1'b1;
                end
            end
            OPC_LUI, OPC_AUIPC: ok = 1'b1;
            default:            ok = 1'b0;
        endcase
        return ok;
    endfunction

    logic [1:0]  state_q,   state_d;
    logic [31:0] instr_q,   instr_d;
    logic [31:0] pc_q,      pc_d;
    logic [31:0] op1_q,     op1_d;
    logic [31:0] op2_q,     op2_d;
    logic        enable_q,  enable_d;
    logic        legal_q,   legal_d;
    logic        retire_q,  retire_d;
    logic        illegal_q, illegal_d;
    logic [31:0] rf_q [32];
    logic [31:0] rf_d [32];

    logic        dec_legal_s;
    logic [31:0] dec_op1_s;
    logic [31:0] dec_op2_s;
    logic [4:0]  wb_rd_s;

    assign wb_rd_s = instr_q[11:7];

    // Operand decode of the offered word. The register file cannot change
    // between acceptance and ISSUE (writes only happen leaving WB), so
    // decoding at acceptance yields the ISSUE-cycle operands as registers.
    always_comb begin
        dec_legal_s = is_legal(in_instr);
        dec_op1_s   = 32'd0;
        dec_op2_s   = 32'd0;
        case (in_instr[6:0])
            OPC_OP: begin
                dec_op1_s = rf_q[in_instr[19:15]];
                dec_op2_s = rf_q[in_instr[24:20]];
            end
            OPC_OPIMM: begin
                dec_op1_s = rf_q[in_instr[19:15]];
                dec_op2_s = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OPC_LUI, OPC_AUIPC: begin
                dec_op1_s = {in_instr[31:12], 12'd0};
                dec_op2_s = 32'd0;
            end
            default: begin
                dec_op1_s = 32'd0;
                dec_op2_s = 32'd0;
            end
        endcase
        if (!dec_legal_s) begin
            dec_op1_s = 32'd0;
            dec_op2_s = 32'd0;
        end else begin
            dec_op1_s = dec_op1_s;
        end
    end

    // Sequencer next-state, operand latch and register-file write logic.
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        pc_d      = pc_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        legal_d   = legal_q;
        enable_d  = 1'b0;
        retire_d  = 1'b0;
        illegal_d = 1'b0;
        rf_d      = rf_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    instr_d  = in_instr;
                    pc_d     = in_pc;
                    op1_d    = dec_op1_s;
                    op2_d    = dec_op2_s;
                    legal_d  = dec_legal_s;
                    enable_d = dec_legal_s;
                    state_d  = ST_ISSUE;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // retire/illegal are registered, so they are set here to
                // be visible during the WB cycle.
                retire_d  = 1'b1;
                illegal_d = ~legal_q;
                state_d   = ST_WB;
            end
            ST_WB: begin
                if (legal_q && (wb_rd_s != 5'd0)) begin
                    rf_d[wb_rd_s] = alu_result;
                end else begin
                    rf_d[0] = 32'd0;
                end
`ifdef ALU_SEQUENCER_ILLEGAL_HALT_EN
                if (legal_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HALT;
                end
`else
                state_d = ST_IDLE;
`endif
            end
`ifdef ALU_SEQUENCER_ILLEGAL_HALT_EN
            ST_HALT: begin
                state_d = ST_HALT;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, operand and register-file flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            instr_q   <= 32'd0;
            pc_q      <= 32'd0;
            op1_q     <= 32'd0;
            op2_q     <= 32'd0;
            enable_q  <= 1'b0;
            legal_q   <= 1'b0;
            retire_q  <= 1'b0;
            illegal_q <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'd0;
            end
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            enable_q  <= enable_d;
            legal_q   <= legal_d;
            retire_q  <= retire_d;
            illegal_q <= illegal_d;
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign alu_instr  = instr_q;
    assign alu_op1    = op1_q;
    assign alu_op2    = op2_q;
    assign alu_pc     = pc_q;
    assign alu_enable = enable_q;
    // A reset arriving during WB abandons the instruction, so the completion
    // pulses are masked for that cycle just as the write is.
    assign retire     = retire_q & ~rst;
    assign illegal    = illegal_q & ~rst;
    assign dbg_rdata  = rf_q[dbg_raddr];

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer : directed, table-driven bench for alu_sequencer.
// A small behavioural RV32I ALU supplies alu_result one cycle after
// alu_enable. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_instr;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [31:0] alu_pc;
    logic        alu_enable;
    logic [31:0] alu_result = 32'd0;
    logic        retire;
    logic        illegal;
    logic [4:0]  dbg_raddr;
    logic [31:0] dbg_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    alu_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_instr  (alu_instr),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_pc     (alu_pc),
        .alu_enable (alu_enable),
        .alu_result (alu_result),
        .retire     (retire),
        .illegal    (illegal),
        .dbg_raddr  (dbg_raddr),
        .dbg_rdata  (dbg_rdata)
    );

    always #5 clk = ~clk;

    // Reference ALU behaviour for the external unit.
    function automatic logic [31:0] alu_model(input logic [31:0] ins,
                                              input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic [31:0] pc);
        logic [31:0] r;
        r = 32'd0;
        case (ins[6:0])
            7'b0110111: r = a;
            7'b0010111: r = a + pc;
            7'b0110011, 7'b0010011: begin
                case (ins[14:12])
                    3'd0: r = ((ins[6:0] == 7'b0110011) && ins[30]) ? a - b : a + b;
                    3'd1: r = a << b[4:0];
                    3'd2: r = {31'd0, $signed(a) < $signed(b)};
                    3'd3: r = {31'd0, a < b};
                    3'd4: r = a ^ b;
                    3'd5: r = ins[30] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
                    3'd6: r = a | b;
                    default: r = a & b;
                endcase
            end
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        if (alu_enable) alu_result <= alu_model(alu_instr, alu_op1, alu_op2, alu_pc);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic [31:0] rd_val;
    } vec_t;

    vec_t vecs [8];

    // Issue one legal instruction starting at an IDLE falling edge; returns at
    // the following IDLE falling edge so dependent vectors run back to back.
    task automatic run_vec(input vec_t v, input int idx);
        check($sformatf("v%0d_ready", idx), {31'd0, in_ready}, 32'd1);
        in_instr = v.instr;
        in_pc    = v.pc;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check($sformatf("v%0d_issue_en", idx), {31'd0, alu_enable}, 32'd1);
        check($sformatf("v%0d_op1", idx), alu_op1, v.op1);
        check($sformatf("v%0d_op2", idx), alu_op2, v.op2);
        check($sformatf("v%0d_pc", idx), alu_pc, v.pc);
        check($sformatf("v%0d_instr", idx), alu_instr, v.instr);
        check($sformatf("v%0d_early_retire", idx), {31'd0, retire}, 32'd0);
        check($sformatf("v%0d_busy", idx), {31'd0, in_ready}, 32'd0);
        dbg_raddr = v.rd;
        @(negedge clk);
        check($sformatf("v%0d_retire", idx), {31'd0, retire}, 32'd1);
        check($sformatf("v%0d_illegal", idx), {31'd0, illegal}, 32'd0);
        check($sformatf("v%0d_wb_en", idx), {31'd0, alu_enable}, 32'd0);
        check($sformatf("v%0d_wb_op1", idx), alu_op1, v.op1);
        check($sformatf("v%0d_wb_op2", idx), alu_op2, v.op2);
        @(negedge clk);
        check($sformatf("v%0d_rd", idx), dbg_rdata, v.rd_val);
        check($sformatf("v%0d_retire_once", idx), {31'd0, retire}, 32'd0);
    endtask

    // Apply synchronous reset for a few cycles, ending at a falling edge.
    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Issue an illegal word; rd_chk must stay unwritten.
    task automatic do_illegal(input logic [31:0] ins, input logic [4:0] rd_chk, input string nm);
        check({nm, "_ready"}, {31'd0, in_ready}, 32'd1);
        in_instr = ins;
        in_pc    = 32'h0000_0200;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check({nm, "_no_en"}, {31'd0, alu_enable}, 32'd0);
        dbg_raddr = rd_chk;
        @(negedge clk);
        check({nm, "_retire"}, {31'd0, retire}, 32'd1);
        check({nm, "_illegal"}, {31'd0, illegal}, 32'd1);
        check({nm, "_wb_no_en"}, {31'd0, alu_enable}, 32'd0);
        @(negedge clk);
        check({nm, "_no_write"}, dbg_rdata, 32'd0);
        check({nm, "_illegal_once"}, {31'd0, illegal}, 32'd0);
`ifdef ALU_SEQUENCER_ILLEGAL_HALT_EN
        check({nm, "_halt"}, {31'd0, in_ready}, 32'd0);
        repeat (4) @(negedge clk);
        check({nm, "_halt_held"}, {31'd0, in_ready}, 32'd0);
        do_reset();
        check({nm, "_halt_cleared"}, {31'd0, in_ready}, 32'd1);
`else
        check({nm, "_back_idle"}, {31'd0, in_ready}, 32'd1);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc;
        int ret;
        logic [31:0] any_nonzero;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = 32'd0;
        in_pc     = 32'd0;
        dbg_raddr = 5'd0;

        //            instr          pc             op1            op2            rd     rd_val
        vecs[0] = '{32'h0050_0093, 32'h0000_0000, 32'h0000_0000, 32'h0000_0005, 5'd1, 32'h0000_0005};
        vecs[1] = '{32'hFFF0_0093, 32'h0000_0004, 32'h0000_0000, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFF};
        vecs[2] = '{32'h4040_D113, 32'h0000_0008, 32'hFFFF_FFFF, 32'h0000_0404, 5'd2, 32'hFFFF_FFFF};
        vecs[3] = '{32'h1234_51B7, 32'h0000_000C, 32'h1234_5000, 32'h0000_0000, 5'd3, 32'h1234_5000};
        vecs[4] = '{32'h0000_1217, 32'h0000_0100, 32'h0000_1000, 32'h0000_0000, 5'd4, 32'h0000_1100};
        vecs[5] = '{32'h0041_82B3, 32'h0000_0104, 32'h1234_5000, 32'h0000_1100, 5'd5, 32'h1234_6100};
        vecs[6] = '{32'h4032_0333, 32'h0000_0108, 32'h0000_1100, 32'h1234_5000, 5'd6, 32'hEDCB_C100};
        vecs[7] = '{32'h0070_0013, 32'h0000_010C, 32'h0000_0000, 32'h0000_0007, 5'd0, 32'h0000_0000};

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_en", {31'd0, alu_enable}, 32'd0);
        check("rst_retire", {31'd0, retire}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        check("rst_instr", alu_instr, 32'd0);
        check("rst_op1", alu_op1, 32'd0);
        check("rst_op2", alu_op2, 32'd0);
        check("rst_pc", alu_pc, 32'd0);
        any_nonzero = 32'd0;
        for (int i = 0; i < 32; i++) begin
            dbg_raddr = 5'(i);
            #1;
            any_nonzero = any_nonzero | dbg_rdata;
        end
        check("rst_regfile", any_nonzero, 32'd0);
        @(negedge clk);

        // Table of legal instructions, back to back
        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end

        // in_valid held high: one acceptance and one retire per 3 cycles
        in_instr = 32'h0070_0013;
        in_pc    = 32'h0000_0300;
        in_valid = 1'b1;
        acc = 0;
        ret = 0;
        for (int k = 0; k < 9; k++) begin
            if (in_ready) acc++;
            @(negedge clk);
            if (retire) ret++;
        end
        in_valid = 1'b0;
        check("thru_accepts", 32'(acc), 32'd3);
        check("thru_retires", 32'(ret), 32'd3);
        dbg_raddr = 5'd0;
        #1;
        check("thru_x0", dbg_rdata, 32'd0);
        @(negedge clk);

        // Illegal encodings
        do_illegal(32'h0210_83B3, 5'd7, "ill_f7");
        @(negedge clk);
        do_illegal(32'h0000_0000, 5'd0, "ill_zero");
        @(negedge clk);

        // Reset during ISSUE of ADDI x5,x0,9 abandons it
        in_instr = 32'h0090_0293;
        in_pc    = 32'h0000_0400;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("rsti_issue_en", {31'd0, alu_enable}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rsti_no_retire", {31'd0, retire}, 32'd0);
        check("rsti_ready", {31'd0, in_ready}, 32'd1);
        dbg_raddr = 5'd5;
        @(negedge clk);
        check("rsti_no_retire2", {31'd0, retire}, 32'd0);
        check("rsti_x5", dbg_rdata, 32'd0);

        // Reset wins over a simultaneous handshake
        in_instr = 32'h0050_0093;
        in_valid = 1'b1;
        rst      = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rstp_no_issue", {31'd0, alu_enable}, 32'd0);
        check("rstp_ready", {31'd0, in_ready}, 32'd1);
        check("rstp_instr", alu_instr, 32'd0);
        @(negedge clk);
        check("rstp_no_retire", {31'd0, retire}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL: clk  input  1  rising-edge clock.
REQ-002 SHALL: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL: in_instr  input  32  RV32I instruction word offered for issue.
REQ-004 SHALL: in_pc  input  32  address of in_instr.
REQ-005 SHALL: in_valid  input  1  in_instr/in_pc valid.
REQ-006 SHALL: in_ready  output  1  sequencer can accept; transfer when in_valid&in_ready at clk edge.
REQ-007 SHALL: alu_instr  output  32  latched instruction driven to ALU.
REQ-008 SHALL: alu_op1, alu_op2, alu_pc  output  32 each  ALU operands.
REQ-009 SHALL: alu_enable  output  1  one-cycle ALU issue strobe.
REQ-010 SHALL: alu_result  input  32  ALU registered result, valid the cycle after alu_enable.
REQ-011 SHALL: retire  output  1  one-cycle pulse, instruction completed.
REQ-012 SHALL: illegal  output  1  one-cycle pulse with retire, instruction not ALU-class.
REQ-013 SHALL: dbg_raddr  input  5 / dbg_rdata  output  32  combinational register-file read port.

Function
REQ-014 SHALL contain a 32x32 register file; x0 reads 0, writes to x0 discarded.
REQ-015 SHALL implement FSM IDLE -> ISSUE -> WB -> IDLE; in_ready=1 only in IDLE.
REQ-016 IDLE: on handshake latch in_instr/in_pc, go ISSUE; else stay.
REQ-017 ISSUE: alu_enable=1 for exactly this cycle if legal, operands decoded from latched instruction and current register file; go WB.
REQ-018 WB: write alu_result to rd (legal, rd!=0), pulse retire; go IDLE; handshake-to-retire latency 2 cycles, throughput 1 per 3 cycles.
REQ-019 Decode: opcode 0110011 (funct7 0x00, or 0x20 with funct3 000/101): op1=x[rs1], op2=x[rs2].
REQ-020 Decode: opcode 0010011: op1=x[rs1], op2=sign-extended instr[31:20]; funct3 001 requires funct7 0x00, funct3 101 requires 0x00/0x20.
REQ-021 Decode: LUI 0110111: op1={instr[31:12],12'b0}, op2=0; AUIPC 0010111: op1 same, alu_pc=latched pc.
REQ-022 Any other encoding is illegal: no alu_enable, no register write, retire and illegal pulse in WB.
REQ-023 alu_instr/alu_op1/alu_op2/alu_pc SHALL hold stable from ISSUE through WB; alu_pc=latched pc for all instructions.
REQ-024 Back-to-back dependent instructions SHALL read the value written in prior WB (no hazard; write completes before next ISSUE).
REQ-025 dbg_rdata SHALL reflect register file state after the last completed clock edge.

Reset
REQ-026 rst SHALL force IDLE, clear all 32 registers, latched instr/pc to 0, alu_* outputs, alu_enable, retire, illegal to 0; in_ready=1 first cycle after reset.
REQ-027 rst in ISSUE or WB SHALL abandon instruction: no register write, no retire.
REQ-028 rst SHALL take priority over any handshake in the same cycle.

Configuration
REQ-029 Macro ALU_SEQUENCER_ILLEGAL_HALT_EN defined: after an illegal instruction retires, FSM enters HALT, in_ready=0 until rst.
REQ-030 Macro undefined: illegal instruction retires as NOP, FSM returns to IDLE; HALT state absent.

Verification
REQ-031 After reset, ADDI x1,x0,5 (0x00500093) -> alu_enable 1 cycle with op1=0, op2=5; retire 2 cycles after handshake; dbg x1=5.
REQ-032 ADDI x1,x0,-1 then SRAI x2,x1,4 (0x4040D113) -> op2 low bits 4, funct7 0x20 accepted; x2=0xFFFFFFFF.
REQ-033 LUI x3,0x12345 then AUIPC x4,1 at pc 0x100 -> op1=0x12345000; AUIPC op1=0x1000, alu_pc=0x100, x4=0x1100.
REQ-034 ADDI x0,x0,7 -> retire pulses, dbg x0=0; in_valid held high continuously -> one acceptance per 3 cycles.
REQ-035 Word 0x00000000 -> illegal+retire, no alu_enable, no writes; with ALU_SEQUENCER_ILLEGAL_HALT_EN in_ready stays 0 until rst, without it returns to 1 next cycle.
REQ-036 rst asserted during ISSUE of ADDI x5,x0,9 -> no retire, x5=0, in_ready=1 after reset.
